// File: rtl/regfile_mp.sv
`default_nettype none
// ============================================================================
// Module   : regfile_mp
// Purpose  : Multi-port register file with a sequential post-reset clear, an optional
//            same-cycle write-to-read bypass and a per-register busy scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module regfile_mp #(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 32,
    parameter int AW       = $clog2(DEPTH),
    parameter int NUM_RD   = 2,
    parameter int NUM_WR   = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_RD*AW-1:0]    rd_addr,
    output logic [NUM_RD*WIDTH-1:0] rd_data,
    output logic [NUM_RD-1:0]       rd_busy,
    input  logic [NUM_WR-1:0]       wr_en,
    input  logic [NUM_WR*AW-1:0]    wr_addr,
    input  logic [NUM_WR*WIDTH-1:0] wr_data,
    input  logic                    claim_en,
    input  logic [AW-1:0]           claim_addr,
    output logic                    init_done
);

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam logic [AW-1:0] c_LAST = AW'(DEPTH - 1);

    state_t           state_q, state_d;
    logic [AW-1:0]    cnt_q, cnt_d;
    logic [DEPTH-1:0] busy_q, busy_d;
    logic [WIDTH-1:0] mem_q [DEPTH];

    logic              w_run;
    logic [NUM_WR-1:0] w_wr_ok;

    assign w_run     = (state_q == ST_RUN);
    assign init_done = w_run;

    // A write is committed only if it does not target the hardwired zero register.
    for (genvar j = 0; j < NUM_WR; j++) begin : g_wr
        assign w_wr_ok[j] = wr_en[j] &&
                            !((ZERO_REG != 0) && (wr_addr[j*AW +: AW] == '0));
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_INIT: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == c_LAST) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN:  state_d = ST_RUN;
            default: state_d = ST_INIT;
        endcase
    end

    // Claims are applied after clears so a same-cycle claim keeps the register busy.
    always_comb begin
        busy_d = busy_q;
        if (w_run) begin
            for (int j = 0; j < NUM_WR; j++) begin
                if (wr_en[j]) begin
                    busy_d[wr_addr[j*AW +: AW]] = 1'b0;
                end
            end
            if (claim_en) begin
                busy_d[claim_addr] = 1'b1;
            end
        end
        if (ZERO_REG != 0) begin
            busy_d[0] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_INIT;
            cnt_q   <= '0;
            busy_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
        end
    end

    // Storage has no reset; later ports are assigned last so the higher index wins.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (!w_run) begin
                mem_q[cnt_q] <= '0;
            end else begin
                for (int j = 0; j < NUM_WR; j++) begin
                    if (w_wr_ok[j]) begin
                        mem_q[wr_addr[j*AW +: AW]] <= wr_data[j*WIDTH +: WIDTH];
                    end
                end
            end
        end
    end

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [AW-1:0]    w_ra;
        logic [WIDTH-1:0] w_val;

        assign w_ra = rd_addr[i*AW +: AW];

        always_comb begin
            w_val = mem_q[w_ra];
            if (BYPASS != 0) begin
                for (int j = 0; j < NUM_WR; j++) begin
                    if (wr_en[j] && (wr_addr[j*AW +: AW] == w_ra)) begin
                        w_val = wr_data[j*WIDTH +: WIDTH];
                    end
                end
            end
            if (!w_run || ((ZERO_REG != 0) && (w_ra == '0))) begin
                w_val = '0;
            end
        end

        assign rd_data[i*WIDTH +: WIDTH] = w_val;
        assign rd_busy[i]                = w_run & busy_q[w_ra];
    end

endmodule
`default_nettype wire

// File: tb/tb_regfile_mp.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_mp
// Purpose  : Self-checking bench for regfile_mp; bypass and non-bypass copies share stimulus.
// Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_mp;

    logic        clk;
    logic        rst_n;
    logic [9:0]  rd_addr;
    logic [63:0] rd_data_b, rd_data_n;
    logic [1:0]  rd_busy_b, rd_busy_n;
    logic [1:0]  wr_en;
    logic [9:0]  wr_addr;
    logic [63:0] wr_data;
    logic        claim_en;
    logic [4:0]  claim_addr;
    logic        init_done_b, init_done_n;

    regfile_mp #(.BYPASS(1)) u_byp (
        .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data_b),
        .rd_busy(rd_busy_b), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .claim_en(claim_en), .claim_addr(claim_addr), .init_done(init_done_b)
    );

    regfile_mp #(.BYPASS(0)) u_nob (
        .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data_n),
        .rd_busy(rd_busy_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .claim_en(claim_en), .claim_addr(claim_addr), .init_done(init_done_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_err = 0;
    int n_chk = 0;

    // Reference model: plain arrays updated from the behavioural rules.
    bit          m_init = 1'b1;
    int          m_cnt  = 0;
    logic [31:0] m_mem  [32];
    bit          m_busy [32];
    bit          chk_en = 1'b0;

    logic [63:0] s_rdb, s_rdn;
    logic [1:0]  s_bsyb, s_bsyn;

    typedef struct {
        logic [4:0]  ra;
        logic [1:0]  we;
        logic [4:0]  wa0;
        logic [4:0]  wa1;
        logic [31:0] wd0;
        logic [31:0] wd1;
        logic        ce;
        logic [4:0]  ca;
        logic [31:0] e_byp;
        logic [31:0] e_nob;
        logic        e_busy;
    } vec_t;

    vec_t tbl [14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] exp_rd(input logic [4:0] a, input bit byp);
        logic [31:0] v;
        if (m_init || a == 5'd0) return 32'd0;
        v = m_mem[a];
        if (byp) begin
            for (int j = 0; j < 2; j++) begin
                if (wr_en[j] && wr_addr[j*5 +: 5] == a) v = wr_data[j*32 +: 32];
            end
        end
        return v;
    endfunction

    function automatic logic [31:0] exp_busy(input logic [4:0] a);
        if (m_init) return 32'd0;
        return {31'd0, m_busy[a]};
    endfunction

    task automatic model_update();
        if (!rst_n) begin
            m_init = 1'b1;
            m_cnt  = 0;
            for (int k = 0; k < 32; k++) m_busy[k] = 1'b0;
        end else if (m_init) begin
            m_mem[m_cnt] = 32'd0;
            m_cnt++;
            if (m_cnt == 32) m_init = 1'b0;
        end else begin
            for (int j = 0; j < 2; j++) begin
                if (wr_en[j] && wr_addr[j*5 +: 5] != 5'd0)
                    m_mem[wr_addr[j*5 +: 5]] = wr_data[j*32 +: 32];
            end
            for (int j = 0; j < 2; j++) begin
                if (wr_en[j]) m_busy[wr_addr[j*5 +: 5]] = 1'b0;
            end
            if (claim_en && claim_addr != 5'd0) m_busy[claim_addr] = 1'b1;
        end
    endtask

    task automatic do_cycle();
        logic [4:0] a;
        @(negedge clk);
        s_rdb  = rd_data_b;
        s_rdn  = rd_data_n;
        s_bsyb = rd_busy_b;
        s_bsyn = rd_busy_n;
        if (chk_en) begin
            for (int i = 0; i < 2; i++) begin
                a = rd_addr[i*5 +: 5];
                chk($sformatf("model_rd_byp[%0d] a=%0d", i, a), rd_data_b[i*32 +: 32], exp_rd(a, 1'b1));
                chk($sformatf("model_rd_nob[%0d] a=%0d", i, a), rd_data_n[i*32 +: 32], exp_rd(a, 1'b0));
                chk($sformatf("model_busy_byp[%0d] a=%0d", i, a), {31'd0, rd_busy_b[i]}, exp_busy(a));
                chk($sformatf("model_busy_nob[%0d] a=%0d", i, a), {31'd0, rd_busy_n[i]}, exp_busy(a));
            end
            chk("model_init_done_byp", {31'd0, init_done_b}, {31'd0, ~m_init});
            chk("model_init_done_nob", {31'd0, init_done_n}, {31'd0, ~m_init});
        end
        @(posedge clk);
        model_update();
        #1;
    endtask

    function automatic logic [4:0] rnd_addr();
        if ($urandom_range(0, 1) == 1) return 5'($urandom_range(0, 7));
        return 5'($urandom_range(0, 31));
    endfunction

    task automatic rand_in();
        rd_addr    = {rnd_addr(), rnd_addr()};
        wr_en      = 2'($urandom_range(0, 3));
        wr_addr    = {rnd_addr(), rnd_addr()};
        wr_data    = {$urandom, $urandom};
        claim_en   = 1'($urandom_range(0, 1));
        claim_addr = rnd_addr();
    endtask

    task automatic idle_in();
        wr_en    = 2'b00;
        claim_en = 1'b0;
    endtask

    task automatic wait_init(input string name);
        int n;
        n = 0;
        while (init_done_b !== 1'b1 && n < 100) begin
            rand_in();
            do_cycle();
            n++;
        end
        idle_in();
        chk(name, n, 32);
    endtask

    task automatic sweep_zero(input string name);
        idle_in();
        for (int k = 0; k < 16; k++) begin
            rd_addr = {5'(2*k + 1), 5'(2*k)};
            do_cycle();
            chk($sformatf("%s_data_byp r%0d", name, 2*k), s_rdb[31:0], 32'd0);
            chk($sformatf("%s_data_nob r%0d", name, 2*k + 1), s_rdn[63:32], 32'd0);
            chk($sformatf("%s_busy r%0d/r%0d", name, 2*k, 2*k + 1), {30'd0, s_bsyb}, 32'd0);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int k = 0; k < 32; k++) begin
            m_mem[k]  = 32'd0;
            m_busy[k] = 1'b0;
        end
        //                ra     we     wa0    wa1    wd0            wd1         ce    ca     e_byp          e_nob          busy
        tbl[0]  = '{5'd5, 2'b01, 5'd5, 5'd0, 32'hDEADBEEF, 32'h0,      1'b0, 5'd0, 32'hDEADBEEF, 32'h0,        1'b0};
        tbl[1]  = '{5'd5, 2'b00, 5'd0, 5'd0, 32'h0,        32'h0,      1'b0, 5'd0, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0};
        tbl[2]  = '{5'd0, 2'b01, 5'd0, 5'd0, 32'h1234,     32'h0,      1'b0, 5'd0, 32'h0,        32'h0,        1'b0};
        tbl[3]  = '{5'd0, 2'b00, 5'd0, 5'd0, 32'h0,        32'h0,      1'b0, 5'd0, 32'h0,        32'h0,        1'b0};
        tbl[4]  = '{5'd7, 2'b11, 5'd7, 5'd7, 32'h11,       32'h22,     1'b0, 5'd0, 32'h22,       32'h0,        1'b0};
        tbl[5]  = '{5'd7, 2'b00, 5'd0, 5'd0, 32'h0,        32'h0,      1'b0, 5'd0, 32'h22,       32'h22,       1'b0};
        tbl[6]  = '{5'd3, 2'b00, 5'd0, 5'd0, 32'h0,        32'h0,      1'b1, 5'd3, 32'h0,        32'h0,        1'b0};
        tbl[7]  = '{5'd3, 2'b00, 5'd0, 5'd0, 32'h0,        32'h0,      1'b0, 5'd0, 32'h0,        32'h0,        1'b1};
        tbl[8]  = '{5'd3, 2'b01, 5'd3, 5'd0, 32'h33,       32'h0,      1'b0, 5'd0, 32'h33,       32'h0,        1'b1};
        tbl[9]  = '{5'd3, 2'b00, 5'd0, 5'd0, 32'h0,        32'h0,      1'b0, 5'd0, 32'h33,       32'h33,       1'b0};
        tbl[10] = '{5'd3, 2'b10, 5'd0, 5'd3, 32'h0,        32'h44,     1'b1, 5'd3, 32'h44,       32'h33,       1'b0};
        tbl[11] = '{5'd3, 2'b00, 5'd0, 5'd0, 32'h0,        32'h0,      1'b0, 5'd0, 32'h44,       32'h44,       1'b1};
        tbl[12] = '{5'd0, 2'b00, 5'd0, 5'd0, 32'h0,        32'h0,      1'b1, 5'd0, 32'h0,        32'h0,        1'b0};
        tbl[13] = '{5'd0, 2'b00, 5'd0, 5'd0, 32'h0,        32'h0,      1'b0, 5'd0, 32'h0,        32'h0,        1'b0};

        rst_n      = 1'b0;
        rd_addr    = 10'd0;
        wr_en      = 2'b00;
        wr_addr    = 10'd0;
        wr_data    = 64'd0;
        claim_en   = 1'b0;
        claim_addr = 5'd0;

        // Two reset edges, then release with writes and claims driven during the clear.
        @(posedge clk);
        model_update();
        #1;
        chk_en = 1'b1;
        do_cycle();
        chk("reset_init_done", {31'd0, init_done_b}, 32'd0);
        chk("reset_busy", {30'd0, rd_busy_b}, 32'd0);
        rst_n = 1'b1;
        wait_init("init_len_first");
        sweep_zero("post_init");

        for (int k = 0; k < 14; k++) begin
            rd_addr    = {5'd0, tbl[k].ra};
            wr_en      = tbl[k].we;
            wr_addr    = {tbl[k].wa1, tbl[k].wa0};
            wr_data    = {tbl[k].wd1, tbl[k].wd0};
            claim_en   = tbl[k].ce;
            claim_addr = tbl[k].ca;
            do_cycle();
            chk($sformatf("vec%0d_rd_byp", k), s_rdb[31:0], tbl[k].e_byp);
            chk($sformatf("vec%0d_rd_nob", k), s_rdn[31:0], tbl[k].e_nob);
            chk($sformatf("vec%0d_busy_byp", k), {31'd0, s_bsyb[0]}, {31'd0, tbl[k].e_busy});
            chk($sformatf("vec%0d_busy_nob", k), {31'd0, s_bsyn[0]}, {31'd0, tbl[k].e_busy});
        end

        for (int k = 0; k < 400; k++) begin
            rand_in();
            do_cycle();
        end

        // Reset in RUN with writes pending, then a second reset at clear count 10.
        rand_in();
        rst_n = 1'b0;
        do_cycle();
        rst_n = 1'b1;
        for (int k = 0; k < 10; k++) begin
            rand_in();
            do_cycle();
        end
        rand_in();
        rst_n = 1'b0;
        do_cycle();
        chk("mid_init_reset_done", {31'd0, init_done_b}, 32'd0);
        rst_n = 1'b1;
        wait_init("init_len_restart");
        sweep_zero("post_restart");

        for (int k = 0; k < 100; k++) begin
            rand_in();
            do_cycle();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-port integer register file, successor to the single-write/dual-read core register file.
- Adds the following features:
  - configurable width, depth and port counts
  - optional same-cycle write-to-read bypass
  - sequential hardware clear after reset
  - per-register busy scoreboard for the pipeline hazard unit
- Sits between decode (reads, busy claims) and writeback (writes, busy clears).

Parameters:
- WIDTH, 32, data bits per register
- DEPTH, 32, number of registers; power of two, >= 2
- AW, $clog2(DEPTH), address width; derived, do not override
- NUM_RD, 2, number of read ports, 1..4
- NUM_WR, 2, number of write ports, 1..2
- ZERO_REG, 1, 1 = register 0 reads 0, ignores writes, never busy
- BYPASS, 1, 1 = same-cycle write data forwarded to matching reads

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  synchronous reset, active-low
- rd_addr  in  NUM_RD*AW  read addresses; port i at bits [i*AW +: AW]
- rd_data  out  NUM_RD*WIDTH  read data; port i at bits [i*WIDTH +: WIDTH]
- rd_busy  out  NUM_RD  scoreboard busy bit of each rd_addr
- wr_en  in  NUM_WR  per-port write enable
- wr_addr  in  NUM_WR*AW  write addresses
- wr_data  in  NUM_WR*WIDTH  write data
- claim_en  in  1  mark claim_addr busy (instruction issued with destination)
- claim_addr  in  AW  destination being claimed
- init_done  out  1  1 = clear sequence finished, file usable

Behaviour:
- Reset: rst_n sampled low at a clk edge gives the following next cycle:
  - state = INIT
  - clear counter = 0
  - all busy bits = 0
  - init_done = 0
  - Register contents are not reset directly.
- INIT state:
  - Each cycle writes 0 to register[counter], then counter += 1.
  - After clearing entry DEPTH-1, state = RUN and init_done = 1 on the next cycle. Total DEPTH cycles from reset release.
  - wr_en and claim_en are ignored.
  - rd_data = 0 and rd_busy = 0 on all ports.
- Reset asserted mid-INIT restarts the counter at 0.
- Reset asserted in RUN returns to INIT. Pending writes in that cycle are dropped.
- RUN state writes:
  - wr_en[j] writes wr_data[j] to register[wr_addr[j]] at the clk edge; visible on reads the next cycle.
  - Two write ports to the same address in one cycle: the higher port index wins.
  - ZERO_REG=1: writes to address 0 are discarded.
- RUN state reads:
  - Combinational, zero cycles from rd_addr to rd_data.
  - ZERO_REG=1 and rd_addr=0 gives rd_data = 0, regardless of writes or bypass.
  - BYPASS=1 with a read address matching an enabled write address in the same cycle returns that wr_data (highest matching write port). BYPASS=0 returns the stored value.
- Scoreboard (RUN only):
  - claim_en sets busy[claim_addr].
  - Any enabled write port clears busy[wr_addr].
  - Claim and clear of the same address in the same cycle: claim wins, busy = 1.
  - Claim of address 0 with ZERO_REG=1 is ignored.
  - rd_busy[i] = busy[rd_addr[i]], combinational.
  - rd_busy is not bypassed: a same-cycle clear becomes visible the next cycle.
- Widths:
  - Addresses are unsigned.
  - Out-of-range addresses cannot occur because DEPTH = 2^AW.

Test Plan:
- Reset sequencing: hold rst_n=0 for 2 cycles, then release.
  - Expect init_done=0 for exactly 32 cycles, then 1.
  - Every register reads 0 and every rd_busy reads 0 afterwards.
- Reset during INIT: pulse rst_n low at clear count 10. Expect init_done to rise exactly 32 cycles after the second release.
- Write/read and register 0:
  - Write 0xDEADBEEF to reg 5 via port 0. Expect reg 5 to read 0xDEADBEEF on the next cycle.
  - Write 0x1234 to reg 0. Expect reg 0 to read 0 both the same cycle and the next cycle.
- Bypass and port priority: in one cycle, port 0 writes 0x11 to reg 7 and port 1 writes 0x22 to reg 7, with rd_addr[0]=7.
  - BYPASS=1: same-cycle rd_data[0]=0x22.
  - BYPASS=0: same-cycle rd_data[0] = old value.
  - Next cycle: 0x22 in both configurations.
- Scoreboard:
  - claim reg 3: rd_busy=1 next cycle.
  - Write reg 3: rd_busy=0 next cycle.
  - Simultaneous claim and write of reg 3: rd_busy stays 1.
  - claim reg 0: rd_busy stays 0.
- Writes and claims during INIT: drive wr_en and claim_en while init_done=0. Expect every register to read 0 and busy=0 after init_done rises.
